// File: rtl/hsv_control_scheduler.sv
// Frame-synchronous ramp scheduler for the S and V controls of the HSV math datapath.
// Host writes land in shadow targets; each frame_start moves the outputs one bounded step.
module hsv_control_scheduler #(
    parameter int STEP    = 4,
    parameter int MAX_MAG = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_sel,
    input  logic [8:0] cfg_data,
    input  logic       frame_start,
    output logic [8:0] control_S,
    output logic [8:0] control_V,
    output logic       busy,
    output logic       ramp_done
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_STEP    = 2'd2;

    function automatic logic [7:0] sat_mag(input logic [7:0] m);
        return (m > 8'(MAX_MAG)) ? 8'(MAX_MAG) : m;
    endfunction

    // Negative zero collapses to zero because -0 == 0 in two's complement.
    function automatic logic signed [9:0] sm_to_s(input logic [8:0] sm);
        logic signed [9:0] mag;
        mag = signed'({2'b00, sat_mag(sm[7:0])});
        return sm[8] ? -mag : mag;
    endfunction

    function automatic logic [8:0] s_to_sm(input logic signed [9:0] v);
        logic signed [9:0] neg;
        neg = -v;
        return v[9] ? {1'b1, neg[7:0]} : {1'b0, v[7:0]};
    endfunction

    function automatic logic signed [9:0] step_toward(input logic signed [9:0] cur,
                                                      input logic signed [9:0] tgt);
        logic signed [9:0] diff;
        logic signed [9:0] stp;
        stp  = signed'(10'(STEP));
        diff = tgt - cur;
        if (diff > stp) begin
            return cur + stp;
        end else if (diff < -stp) begin
            return cur - stp;
        end
        return tgt;
    endfunction

    logic [1:0]        state_q, state_d;
    logic signed [9:0] shd_s_q, shd_s_d, shd_v_q, shd_v_d;
    logic signed [9:0] tgt_s_q, tgt_s_d, tgt_v_q, tgt_v_d;
    logic signed [9:0] cur_s_q, cur_s_d, cur_v_q, cur_v_d;
    logic [8:0]        ctrl_s_q, ctrl_s_d, ctrl_v_q, ctrl_v_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              at_tgt;

    assign cfg_ready = ~rst & (state_q != ST_STEP);
    assign control_S = ctrl_s_q;
    assign control_V = ctrl_v_q;
    assign busy      = busy_q;
    assign ramp_done = done_q;

    always_comb begin
        state_d  = state_q;
        shd_s_d  = shd_s_q;
        shd_v_d  = shd_v_q;
        tgt_s_d  = tgt_s_q;
        tgt_v_d  = tgt_v_q;
        cur_s_d  = cur_s_q;
        cur_v_d  = cur_v_q;
        ctrl_s_d = ctrl_s_q;
        ctrl_v_d = ctrl_v_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        at_tgt   = 1'b0;

        case (state_q)
            IDLE, WAIT_FRAME: begin
                if (frame_start) begin
                    state_d = ST_STEP;
                    tgt_s_d = shd_s_q;
                    tgt_v_d = shd_v_q;
                end
            end
            ST_STEP: begin
                // frame_start is ignored here so a stretched pulse cannot double-step.
                cur_s_d  = step_toward(cur_s_q, tgt_s_q);
                cur_v_d  = step_toward(cur_v_q, tgt_v_q);
                ctrl_s_d = s_to_sm(cur_s_d);
                ctrl_v_d = s_to_sm(cur_v_d);
                at_tgt   = (cur_s_d == tgt_s_q) && (cur_v_d == tgt_v_q);
                busy_d   = ~at_tgt;
                done_d   = at_tgt && ((cur_s_d != cur_s_q) || (cur_v_d != cur_v_q));
                state_d  = at_tgt ? IDLE : WAIT_FRAME;
            end
            default: state_d = IDLE;
        endcase

        // The copy above reads the old shadow, so a write alongside frame_start waits a frame.
        if (cfg_valid && cfg_ready) begin
            if (cfg_sel) begin
                shd_v_d = sm_to_s(cfg_data);
            end else begin
                shd_s_d = sm_to_s(cfg_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shd_s_q  <= '0;
            shd_v_q  <= '0;
            tgt_s_q  <= '0;
            tgt_v_q  <= '0;
            cur_s_q  <= '0;
            cur_v_q  <= '0;
            ctrl_s_q <= '0;
            ctrl_v_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shd_s_q  <= shd_s_d;
            shd_v_q  <= shd_v_d;
            tgt_s_q  <= tgt_s_d;
            tgt_v_q  <= tgt_v_d;
            cur_s_q  <= cur_s_d;
            cur_v_q  <= cur_v_d;
            ctrl_s_q <= ctrl_s_d;
            ctrl_v_q <= ctrl_v_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: doc/hsv_control_scheduler.md
HSV_CONTROL_SCHEDULER -- requirements
Module: hsv_control_scheduler

Interface
REQ-001 SHALL have parameter STEP, default 4, max magnitude change per channel per frame (1..100).
REQ-002 SHALL have parameter MAX_MAG, default 100, clamp limit for any control magnitude (percent).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid  input  1  host config write request.
REQ-006 SHALL have port cfg_ready  output  1  scheduler can accept a write this cycle.
REQ-007 SHALL have port cfg_sel  input  1  target channel: 0 = S, 1 = V.
REQ-008 SHALL have port cfg_data  input  9  sign-magnitude target: bit8 = subtract, bits7:0 = percent.
REQ-009 SHALL have port frame_start  input  1  single-cycle pulse at start of each video frame.
REQ-010 SHALL have port control_S  output  9  sign-magnitude S control to HSV math datapath.
REQ-011 SHALL have port control_V  output  9  sign-magnitude V control to HSV math datapath.
REQ-012 SHALL have port busy  output  1  high while either output differs from its active target.
REQ-013 SHALL have port ramp_done  output  1  one-cycle pulse when both outputs reach their targets.

Function
REQ-014 SHALL accept a write on any cycle with cfg_valid and cfg_ready both high; no other cycle updates the shadow target.
REQ-015 SHALL store each accepted write into the shadow target for cfg_sel only; the other channel's shadow is unchanged.
REQ-016 SHALL clamp written magnitude to MAX_MAG; it SHALL store 9'h100 (negative zero) as 9'h000.
REQ-017 SHALL convert targets and current values to signed 10-bit internally: +mag or -mag.
REQ-018 SHALL implement FSM states IDLE, WAIT_FRAME, STEP.
REQ-019 SHALL go to STEP on frame_start from IDLE or WAIT_FRAME and copy both shadows into the active targets in that same edge.
REQ-020 SHALL, in STEP, move each current value toward its active target by min(STEP, |target - current|), crossing zero as an ordinary signed step.
REQ-021 SHALL leave STEP after exactly one cycle, going to IDLE if both currents equal the targets, otherwise to WAIT_FRAME.
REQ-022 SHALL hold cfg_ready low only in STEP; a write coinciding with frame_start is accepted but enters the shadow after the copy and takes effect at the next frame.
REQ-023 SHALL register control_S and control_V, updating them only on the clock edge ending the STEP cycle; frame_start in cycle N gives new outputs visible in cycle N+2.
REQ-024 SHALL keep control outputs constant for the rest of each frame, so no mid-frame parameter change reaches the datapath.
REQ-025 SHALL encode outputs as sign-magnitude with bit8 = 1 only for strictly negative values; zero SHALL be 9'h000.
REQ-026 SHALL ignore frame_start arriving while in STEP; this cannot occur with a legal pulse, and it SHALL cause no double step.
REQ-027 SHALL drive busy as a registered signal, high iff either current differs from its active target after the STEP update.
REQ-028 SHALL pulse ramp_done for one cycle, on the cycle after STEP, only when that STEP made both currents equal the targets and at least one current changed.

Reset
REQ-029 SHALL, while rst is high, force state IDLE, all shadows, targets and currents to 0, control_S = control_V = 9'h000, busy = 0, ramp_done = 0, and cfg_ready = 0.
REQ-030 SHALL give rst priority over cfg_valid and frame_start in the same cycle; a reset mid-ramp SHALL abandon the ramp and keep outputs at zero until new writes and frames arrive.
REQ-031 SHALL drive cfg_ready = 1 from the first cycle after rst deasserts.

Verification
REQ-032 SHALL pass this test: write S = 9'h00A (+10) with STEP = 4, then three frame_start pulses -> control_S goes 4, 8, 10; ramp_done pulses once after the third frame; busy falls at the same time.
REQ-033 SHALL pass this test: current V = +6, write V = 9'h105 (-5), STEP = 4 -> control_V goes 9'h002, 9'h102, 9'h105 on successive frames.
REQ-034 SHALL pass this test: write S = 9'h0C8 (+200) -> stored and ramped target is +100; write 9'h100 -> target 9'h000.
REQ-035 SHALL pass this test: cfg_valid together with frame_start, data +20 on S while the target is 0 -> no output change at N+2; the step toward +20 occurs only after the next frame_start.
REQ-036 SHALL pass this test: rst asserted mid-ramp with control_V = 9'h008 -> next cycle control_V = 9'h000, busy = 0; a subsequent frame_start with no writes gives no change and no ramp_done.
REQ-037 SHALL pass this test: no frame_start for 1000 cycles after writes -> outputs remain constant and busy stays 0.
